// File: rtl/mm_array_ctrl.sv
// Sequencer for the NxN systolic matrix-multiply array: clears the array, streams K operand
// reads through per-slice input skew, waits out the pipeline drain and pulses done.
module mm_array_ctrl #(
   parameter int N   = 4,
   parameter int DW  = 8,
   parameter int K_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [K_W-1:0]    k_len,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [K_W-1:0]    rd_addr,
   input  logic [N*DW-1:0]   a_col,
   input  logic [N*DW-1:0]   b_row,
   output logic [N*DW-1:0]   a_feed,
   output logic [N*DW-1:0]   b_feed,
   output logic              pe_enable,
   output logic              pe_rst_n
);

   localparam int DCW = $clog2(4 * N);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(4 * N - 1);
   localparam logic [K_W-1:0] K_ONE = K_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t         state;
   logic [K_W-1:0] k_reg;
   logic [DCW-1:0] dcnt;
   logic           clr_phase;
   logic           vld;
   logic           clr;

   assign clr = (state == S_CLEAR);

   // Outputs are registered alongside the state: each transition loads the values of the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         k_reg     <= '0;
         dcnt      <= '0;
         clr_phase <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         pe_enable <= 1'b0;
         pe_rst_n  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               pe_rst_n <= 1'b1;
               if (start) begin
                  k_reg     <= k_len;
                  clr_phase <= 1'b0;
                  busy      <= 1'b1;
                  pe_rst_n  <= 1'b0;
                  state     <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               clr_phase <= 1'b1;
               if (clr_phase) begin
                  pe_rst_n <= 1'b1;
                  if (k_reg == '0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     rd_en     <= 1'b1;
                     rd_addr   <= '0;
                     pe_enable <= 1'b1;
                     state     <= S_FEED;
                  end
               end
            end
            S_FEED: begin
               // rd_addr doubles as the feed counter; K >= 1 here so k_reg - 1 never underflows.
               if (rd_addr == k_reg - K_ONE) begin
                  rd_en <= 1'b0;
                  dcnt  <= '0;
                  state <= S_DRAIN;
               end else begin
                  rd_addr <= rd_addr + K_ONE;
               end
            end
            S_DRAIN: begin
               if (dcnt == DRAIN_LAST) begin
                  busy      <= 1'b0;
                  pe_enable <= 1'b0;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Buffer data arrives one cycle after rd_en, so the registered strobe marks it valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= 1'b0;
      end else if (clr) begin
         vld <= 1'b0;
      end else begin
         vld <= rd_en;
      end
   end

   // Slice g is delayed by 2g+1 stages; invalid data is replaced by zero at the chain entry.
   for (genvar g = 0; g < N; g++) begin : g_skew
      localparam int D = 2 * g + 1;
      logic [DW-1:0] a_sr [D];
      logic [DW-1:0] b_sr [D];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s < D; s++) begin
               a_sr[s] <= '0;
               b_sr[s] <= '0;
            end
         end else if (clr) begin
            for (int s = 0; s < D; s++) begin
               a_sr[s] <= '0;
               b_sr[s] <= '0;
            end
         end else begin
            a_sr[0] <= vld ? a_col[g*DW +: DW] : '0;
            b_sr[0] <= vld ? b_row[g*DW +: DW] : '0;
            for (int s = 1; s < D; s++) begin
               a_sr[s] <= a_sr[s-1];
               b_sr[s] <= b_sr[s-1];
            end
         end
      end

      assign a_feed[g*DW +: DW] = a_sr[D-1];
      assign b_feed[g*DW +: DW] = b_sr[D-1];
   end

endmodule
